divclk_edge_counter: RTL

Downstream consumer of the clock-division stage on the Basys3 counter design. It takes the divider's one-bit `count_out` level as `div_in`, detects its rising edges in the system clock domain and counts them up to a programmable limit. It emits a one-cycle `tick` per edge and holds `done` until the controller acknowledges. It turns the divided waveform into a bounded event count for the display and control logic.

---
 rtl/divclk_edge_counter_pkg.sv | 15 +
 rtl/divclk_edge_counter_rise.sv | 30 +++
 rtl/divclk_edge_counter.sv | 110 +++++++++++
 3 files changed

// File: rtl/divclk_edge_counter_pkg.sv
// Shared definitions for the divided-clock edge counter.
// Holds the controller state encoding and the default count width, so the
// clock divider and this block agree on the final/limit width.
package divclk_edge_counter_pkg;

   localparam int unsigned DEFAULT_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : divclk_edge_counter_pkg

// File: rtl/divclk_edge_counter_rise.sv
// rise_detect: registered previous-level tracker with a rising-edge strobe.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   load       : snapshot sig into prev so an already-high level is not an edge
//   en         : track sig every cycle and allow rise_c
//   sig        : level to watch
//   rise_c     : combinational one-cycle strobe, sig high while prev low
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   input  logic sig,
   output logic rise_c
);

   logic prev;

   // prev only moves while armed or running; outside that it is don't-care
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
      end else if (load || en) begin
         prev <= sig;
      end
   end

   assign rise_c = en && sig && !prev;

endmodule : rise_detect

// File: rtl/divclk_edge_counter.sv
// divclk_edge_counter: counts rising edges of the divider's count_out level
// up to a limit captured on arming, pulses tick per edge and holds done
// until acknowledged.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   div_in     : divided level from the clock divider
//   enable     : arm and keep counting while high
//   limit      : target edge count, captured in ARM
//   ack        : clears done and returns to idle
//   count      : edges counted since arming (registered)
//   tick       : one-cycle pulse per counted edge (registered)
//   done       : target reached, awaiting ack (registered)
//   busy       : high in ARM and RUN (registered)
module divclk_edge_counter
   import divclk_edge_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_in,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   input  logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             done,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] count_inc;
   logic             arm_c;
   logic             run_c;
   logic             rise_c;

   assign arm_c     = (state == ST_ARM);
   assign run_c     = (state == ST_RUN);
   assign count_inc = count + WIDTH'(1);

   rise_detect u_rise (
      .clk    (clk),
      .reset  (reset),
      .load   (arm_c),
      .en     (run_c),
      .sig    (div_in),
      .rise_c (rise_c)
   );

   // Controller FSM with counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         limit_q <= '0;
         count   <= '0;
         tick    <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         tick <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state <= ST_ARM;
                  busy  <= 1'b1;
               end
            end
            ST_ARM: begin
               limit_q <= limit;
               if (limit == '0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // abort wins over an edge in the same cycle
               if (!enable) begin
                  state <= ST_IDLE;
                  count <= '0;
                  busy  <= 1'b0;
               end else if (rise_c) begin
                  count <= count_inc;
                  tick  <= 1'b1;
                  // count never exceeds limit_q, so it cannot wrap
                  if (count_inc == limit_q) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (ack) begin
                  state <= ST_IDLE;
                  done  <= 1'b0;
                  count <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : divclk_edge_counter
